sp_serial_block: RTL and testbench

SP_SERIAL_BLOCK -- requirements
Module: sp_serial_block

---
 rtl/sp_serial_block.sv | 132 +++++++++++++
 tb/tb_sp_serial_block.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_serial_block.sv
// Serial DES f-function core: latches a 48-bit pre-S-box word, runs one S-box
// per clock through S1..S8 into a 32-bit accumulator, applies the P
// permutation, then holds the result until the consumer takes it.
module sp_serial_block (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:47] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] data_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] PERM = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Each S-box row packed as 16 nibbles, column 0 in the top nibble.
  localparam logic [63:0] SBOX [8][4] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
      64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
      64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
      64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
      64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
      64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
      64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
      64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
      64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
  };

  // P permutation, stored zero-based: data_out[i] = acc[P_IDX[i]].
  localparam logic [4:0] P_IDX [32] = '{
    5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
    5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
    5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
    5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
  };

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [0:47] din_q, din_d;
  logic [0:31] acc_q, acc_d;
  logic [0:31] dout_q, dout_d;

  logic [5:0]  gbase;
  logic [5:0]  grp;
  logic [1:0]  row;
  logic [3:0]  ncol;
  logic [63:0] row_word;
  logic [3:0]  sout;
  logic [0:31] perm;

  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = dout_q;

  // S-box lookup for the box selected by the counter.
  always_comb begin
    gbase    = 6'd6 * {3'b000, cnt_q};
    grp      = din_q[gbase +: 6];
    row      = {grp[5], grp[0]};
    ncol     = ~grp[4:1];
    row_word = SBOX[cnt_q][row];
    sout     = row_word[{ncol, 2'b00} +: 4];
  end

  // P permutation of the completed accumulator.
  always_comb begin
    perm = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      perm[i] = acc_q[P_IDX[i]];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          din_d   = data_in;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        acc_d[{cnt_q, 2'b00} +: 4] = sout;
        if (cnt_q == 3'd7) state_d = PERM;
        else               cnt_d   = cnt_q + 3'd1;
      end
      PERM: begin
        dout_d  = perm;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_sp_serial_block.sv
// Self-checking bench for sp_serial_block using a scoreboard queue fed by an
// independent DES S/P model.
module tb_sp_serial_block;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:47] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] exp_q [$];

  sp_serial_block dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Reference S-boxes, FIPS 46-3, row-major (row*16 + column).
  int SB [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,
      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,
      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,
      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,
      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,
      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,
      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,
      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,
      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,
      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,
      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,
      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,
      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,
      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,
      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,
      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,
      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  // Reference P table, 1-based DES bit numbers.
  int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  // DES bit n (1-based) lives at packed index width-n here.
  function automatic logic [31:0] sbox_stage(input logic [47:0] x);
    logic [31:0] a;
    logic [5:0]  g;
    int          r, c, v;
    a = '0;
    for (int k = 0; k < 8; k++) begin
      g = x[47-6*k -: 6];
      r = 2 * int'(g[5]) + int'(g[0]);
      c = int'(g[4:1]);
      v = SB[k][r*16+c];
      a[31-4*k -: 4] = 4'(v);
    end
    return a;
  endfunction

  function automatic logic [31:0] perm_stage(input logic [31:0] a);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o[31-i] = a[32-PT[i]];
    return o;
  endfunction

  // Present a word until it is accepted; queue its expected result.
  task automatic accept_word(input logic [47:0] w, output bit ok);
    bit rdy;
    ok       = 1'b0;
    in_valid = 1'b1;
    data_in  = w;
    for (int t = 0; t < 60; t++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (ok) exp_q.push_back(perm_stage(sbox_stage(w)));
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n  = 0;
    ok = out_valid;
    while (!ok && n < budget) begin
      @(posedge clk); #1;
      n++;
      ok = out_valid;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    #3;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: in_ready=%b out_valid=%b data_out=%h, required 0 0 00000000",
               in_ready, out_valid, data_out);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_known_answer;
    bit ok; int n; logic [31:0] e;
    out_ready = 1'b1;
    accept_word(48'h6117BA866527, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL kat_accept: accepted=%b, required 1", ok); end
    wait_valid(20, n, ok);
    n_checks++;
    if (!ok || n != 9) begin
      n_fail++;
      $display("FAIL kat_latency: out_valid after %0d edges (seen=%b), required 9", n, ok);
    end
    n_checks++;
    if (dut.acc_q !== 32'h5C82B597) begin
      n_fail++;
      $display("FAIL kat_acc: acc=%h, required 5C82B597", dut.acc_q);
    end
    n_checks++;
    if (data_out !== 32'h234AA9BB) begin
      n_fail++;
      $display("FAIL kat_data: data_out=%h, required 234AA9BB", data_out);
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("FAIL kat_model: data_out=%h, required %h", data_out, e);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 32'h234AA9BB) begin
      n_fail++;
      $display("FAIL kat_release: out_valid=%b in_ready=%b data_out=%h, required 0 1 234AA9BB",
               out_valid, in_ready, data_out);
    end
  endtask

  task automatic test_reset_mid_sub;
    bit ok; int seen;
    accept_word(48'hA5A5F0F01234, ok);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (data_out !== 32'h234AA9BB || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midsub_hold: data_out=%h in_ready=%b, required 234AA9BB 0", data_out, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (data_out !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midsub_reset: data_out=%h out_valid=%b in_ready=%b, required 00000000 0 0",
               data_out, out_valid, in_ready);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midsub_release: in_ready=%b, required 1", in_ready);
    end
    seen = 0;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midsub_stale: out_valid cycles=%0d, required 0", seen);
    end
  endtask

  task automatic test_all_zero;
    bit ok; int n; logic [31:0] e;
    out_ready = 1'b1;
    accept_word(48'h0, ok);
    wait_valid(20, n, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL zero_valid: out_valid=%b, required 1", out_valid); end
    n_checks++;
    if (dut.acc_q !== 32'hEFA72C4D) begin
      n_fail++;
      $display("FAIL zero_acc: acc=%h, required EFA72C4D", dut.acc_q);
    end
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
    n_checks++;
    if (data_out !== e || e !== perm_stage(32'hEFA72C4D)) begin
      n_fail++;
      $display("FAIL zero_data: data_out=%h, required %h", data_out, perm_stage(32'hEFA72C4D));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bit ok; int n; logic [31:0] e, held; int bad;
    out_ready = 1'b0;
    accept_word(48'h3C3C_9D2E_7711, ok);
    wait_valid(20, n, ok);
    held = data_out;
    e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
    n_checks++;
    if (!ok || held !== e) begin
      n_fail++;
      $display("FAIL bp_data: data_out=%h valid=%b, required %h", held, ok, e);
    end
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      in_valid = t[0];
      data_in  = {16'($urandom), $urandom};
      @(posedge clk); #1;
      if (data_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_stall: %0d cycles unstable, required 0", bad);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== held) begin
      n_fail++;
      $display("FAIL bp_handshake: out_valid=%b in_ready=%b data_out=%h, required 0 1 %h",
               out_valid, in_ready, data_out, held);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [47:0] w [3];
    int acc_cyc [3];
    int got, guard;
    w[0] = 48'h0123456789AB; w[1] = 48'hFFFFFFFFFFFF; w[2] = 48'hDEADBEEFCAFE;
    out_ready = 1'b1;
    got = 0;
    fork
      begin
        bit rdy, done;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          data_in = w[k];
          done = 1'b0;
          for (int t = 0; t < 40 && !done; t++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
              done = 1'b1;
              acc_cyc[k] = cyc;
              exp_q.push_back(perm_stage(sbox_stage(w[k])));
            end
          end
        end
        in_valid = 1'b0;
      end
      begin
        bit ov; logic [31:0] dv, e;
        guard = 0;
        while (got < 3 && guard < 100) begin
          ov = out_valid; dv = data_out;
          @(posedge clk); #1;
          guard++;
          if (ov) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hx;
            n_checks++;
            if (dv !== e) begin
              n_fail++;
              $display("FAIL b2b_data[%0d]: data_out=%h, required %h", got, dv, e);
            end
            got++;
          end
        end
      end
    join
    n_checks++;
    if (got != 3) begin n_fail++; $display("FAIL b2b_count: outputs=%0d, required 3", got); end
    n_checks++;
    if (acc_cyc[1] - acc_cyc[0] != 11 || acc_cyc[2] - acc_cyc[1] != 11) begin
      n_fail++;
      $display("FAIL b2b_spacing: gaps=%0d,%0d, required 11,11",
               acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
  endtask

  task automatic test_random;
    localparam int N = 2500;
    int sent, got;
    sent = 0; got = 0;
    fork
      begin
        bit rdy; logic [47:0] w;
        int guard = 0;
        while (sent < N && guard < 80000) begin
          if (!in_valid || in_ready) begin
            in_valid = ($urandom_range(0, 3) != 0);
            w = {16'($urandom), $urandom};
            data_in = w;
          end
          rdy = in_ready & in_valid;
          @(posedge clk); #1;
          guard++;
          if (rdy) begin
            exp_q.push_back(perm_stage(sbox_stage(w)));
            sent++;
            in_valid = 1'b0;
          end
        end
        in_valid = 1'b0;
      end
      begin
        bit ov; logic [31:0] dv, e;
        int guard = 0;
        while (got < N && guard < 90000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          ov = out_valid; dv = data_out;
          @(posedge clk); #1;
          guard++;
          if (ov && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL rand_extra: output %h with empty scoreboard, required none", dv);
            end else begin
              e = exp_q.pop_front();
              if (dv !== e) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: data_out=%h, required %h", got, dv, e);
              end
            end
            got++;
          end
        end
      end
    join
    out_ready = 1'b1;
    n_checks++;
    if (sent != N || got != N || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_count: sent=%0d got=%0d left=%0d, required %0d %0d 0",
               sent, got, exp_q.size(), N, N);
    end
  endtask

  initial begin
    test_reset;
    test_known_answer;
    test_reset_mid_sub;
    test_all_zero;
    test_backpressure;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
